// File: rtl/assoc_memory_classifier.sv
// Associative-memory classifier: trains per-label prototype hypervectors and predicts by serial
// chunked minimum-Hamming-distance search. Optional macro AM_REJECT_THRESHOLD_EN adds a reject threshold.
module assoc_memory_classifier #(
  parameter int unsigned HV_DIMENSION = 2000,
  parameter int unsigned LABEL_WIDTH  = 5,
  parameter int unsigned MODE_WIDTH   = 1,
  parameter int unsigned NUM_CLASSES  = 5,
  parameter int unsigned CHUNK_WIDTH  = 200,
  parameter int unsigned DIST_WIDTH   = 11
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [MODE_WIDTH-1:0]   ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
`ifdef AM_REJECT_THRESHOLD_EN
  input  logic [DIST_WIDTH-1:0]   ThresholdIn_DI,
`endif
  input  logic                    ReadyIn_SI,
  output logic                    ValidOut_SO,
  output logic [MODE_WIDTH-1:0]   ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
  output logic [DIST_WIDTH-1:0]   DistanceOut_DO
);

  localparam int unsigned NUM_CHUNKS = HV_DIMENSION / CHUNK_WIDTH;
  localparam int unsigned CLASS_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned OFFSET_W   = $clog2(HV_DIMENSION);

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FINISH,
    OUT
  } state_t;

  state_t                    state;
  logic [0:HV_DIMENSION-1]   query_hv;
  logic [MODE_WIDTH-1:0]     query_mode;
  logic [0:HV_DIMENSION-1]   proto [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]    proto_valid;
  logic [CLASS_W-1:0]        class_idx;
  logic [CHUNK_W-1:0]        chunk_idx;
  logic [DIST_WIDTH-1:0]     acc;
  logic [DIST_WIDTH-1:0]     best_dist;
  logic [LABEL_WIDTH-1:0]    best_label;
`ifdef AM_REJECT_THRESHOLD_EN
  logic [DIST_WIDTH-1:0]     threshold;
`endif

  logic                      accept;
  logic                      is_train;
  logic                      label_ok;
  logic [OFFSET_W-1:0]       chunk_base;
  logic [CHUNK_WIDTH-1:0]    query_chunk;
  logic [CHUNK_WIDTH-1:0]    proto_chunk;
  logic [CHUNK_WIDTH-1:0]    diff_chunk;
  logic [DIST_WIDTH-1:0]     chunk_pop;
  logic [DIST_WIDTH-1:0]     acc_sum;

  assign ReadyOut_SO = (state == IDLE) && !Reset_RI;
  assign accept      = ValidIn_SI && ReadyOut_SO;
  assign is_train    = (ModeIn_SI == '0);
  assign label_ok    = (LabelIn_DI < LABEL_WIDTH'(NUM_CLASSES));

  // Chunk datapath: one CHUNK_WIDTH slice of query vs. current prototype per cycle.
  assign chunk_base  = OFFSET_W'(chunk_idx) * OFFSET_W'(CHUNK_WIDTH);
  assign query_chunk = query_hv[chunk_base +: CHUNK_WIDTH];
  assign proto_chunk = proto[class_idx][chunk_base +: CHUNK_WIDTH];
  assign diff_chunk  = query_chunk ^ proto_chunk;

  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < int'(CHUNK_WIDTH); i++) begin
      chunk_pop = chunk_pop + DIST_WIDTH'(diff_chunk[i]);
    end
  end

  assign acc_sum = acc + chunk_pop;

  // Prototype storage; contents survive reset, only the valid bits are cleared.
  always_ff @(posedge Clk_CI) begin
    if (accept && is_train && label_ok) begin
      proto[CLASS_W'(LabelIn_DI)] <= HypervectorIn_DI;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state          <= IDLE;
      proto_valid    <= '0;
      ValidOut_SO    <= 1'b0;
      ModeOut_SO     <= '0;
      LabelOut_DO    <= '0;
      DistanceOut_DO <= '0;
      class_idx      <= '0;
      chunk_idx      <= '0;
      acc            <= '0;
      best_dist      <= '1;
      best_label     <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            query_hv   <= HypervectorIn_DI;
            query_mode <= ModeIn_SI;
`ifdef AM_REJECT_THRESHOLD_EN
            threshold  <= ThresholdIn_DI;
`endif
            if (is_train) begin
              if (label_ok) begin
                proto_valid[CLASS_W'(LabelIn_DI)] <= 1'b1;
              end
              ValidOut_SO    <= 1'b1;
              ModeOut_SO     <= ModeIn_SI;
              LabelOut_DO    <= LabelIn_DI;
              DistanceOut_DO <= label_ok ? '0 : '1;
              state          <= OUT;
            end else begin
              class_idx  <= '0;
              chunk_idx  <= '0;
              acc        <= '0;
              best_dist  <= '1;
              best_label <= '1;
              state      <= COMPUTE;
            end
          end
        end

        COMPUTE: begin
          if (chunk_idx == LAST_CHUNK) begin
            // Strict compare keeps the lowest-index class on ties.
            if (proto_valid[class_idx] && (acc_sum < best_dist)) begin
              best_dist  <= acc_sum;
              best_label <= LABEL_WIDTH'(class_idx);
            end
            acc       <= '0;
            chunk_idx <= '0;
            if (class_idx == LAST_CLASS) begin
              state <= FINISH;
            end else begin
              class_idx <= class_idx + CLASS_W'(1);
            end
          end else begin
            acc       <= acc_sum;
            chunk_idx <= chunk_idx + CHUNK_W'(1);
          end
        end

        FINISH: begin
          ValidOut_SO    <= 1'b1;
          ModeOut_SO     <= query_mode;
          DistanceOut_DO <= best_dist;
`ifdef AM_REJECT_THRESHOLD_EN
          LabelOut_DO    <= (best_dist > threshold) ? '1 : best_label;
`else
          LabelOut_DO    <= best_label;
`endif
          state          <= OUT;
        end

        OUT: begin
          if (ReadyIn_SI) begin
            ValidOut_SO <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_memory_classifier.sv
// Directed bench for assoc_memory_classifier: training, prediction, ties, backpressure and reset abort.
module tb_assoc_memory_classifier;

  localparam int unsigned HV   = 2000;
  localparam int unsigned LW   = 5;
  localparam int unsigned DW   = 11;
  localparam int          PRED_LAT = 51;

  logic            clk;
  logic            rst;
  logic            valid_in;
  logic            ready_out;
  logic [0:0]      mode_in;
  logic [LW-1:0]   label_in;
  logic [0:HV-1]   hv_in;
  logic            ready_in;
  logic            valid_out;
  logic [0:0]      mode_out;
  logic [LW-1:0]   label_out;
  logic [DW-1:0]   dist_out;
`ifdef AM_REJECT_THRESHOLD_EN
  logic [DW-1:0]   threshold;
  assign threshold = '1;
`endif

  assoc_memory_classifier dut (
    .Clk_CI           (clk),
    .Reset_RI         (rst),
    .ValidIn_SI       (valid_in),
    .ReadyOut_SO      (ready_out),
    .ModeIn_SI        (mode_in),
    .LabelIn_DI       (label_in),
    .HypervectorIn_DI (hv_in),
`ifdef AM_REJECT_THRESHOLD_EN
    .ThresholdIn_DI   (threshold),
`endif
    .ReadyIn_SI       (ready_in),
    .ValidOut_SO      (valid_out),
    .ModeOut_SO       (mode_out),
    .LabelOut_DO      (label_out),
    .DistanceOut_DO   (dist_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [0:HV-1] hv_a, hv_b, hv_c, hv_q;
  int            obs_lat;
  logic [0:0]    obs_mode;
  logic [LW-1:0] obs_label;
  logic [DW-1:0] obs_dist;

  // Present one request and hold it until accepted; returns right after the accept edge.
  task automatic start_op(input logic [0:0] m, input logic [LW-1:0] l, input logic [0:HV-1] h,
                          output bit to);
    to = 1'b0;
    @(negedge clk);
    valid_in = 1'b1;
    mode_in  = m;
    label_in = l;
    hv_in    = h;
    for (int i = 0; i < 100 && ready_out !== 1'b1; i++) @(negedge clk);
    if (ready_out !== 1'b1) to = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Count edges from the accept edge until ValidOut_SO is seen; -1 on timeout.
  task automatic wait_result(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 200; i++) begin
      if (valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!seen) lat = -1;
    obs_mode  = mode_out;
    obs_label = label_out;
    obs_dist  = dist_out;
  endtask

  task automatic run_op(input logic [0:0] m, input logic [LW-1:0] l, input logic [0:HV-1] h);
    bit to;
    start_op(m, l, h, to);
    wait_result(obs_lat);
    if (to) obs_lat = -1;
    if (ready_in) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    mode_in  = '0;
    label_in = '0;
    hv_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", valid_out); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready_in_reset got=%0b want=0", ready_out); end
    total++; if ({mode_out, label_out, dist_out} !== '0) begin
      bad++; $display("FAIL reset_outputs got mode=%0d label=%0d dist=%0d want=0/0/0", mode_out, label_out, dist_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%0b want=1", ready_out); end
  endtask

  task automatic test_train_predict;
    run_op(1'b0, 5'd0, hv_a);
    total++; if (obs_lat < 0 || obs_lat > 1 || obs_label !== 5'd0 || obs_dist !== 11'd0 || obs_mode !== 1'b0) begin
      bad++; $display("FAIL train0 got lat=%0d label=%0d dist=%0d mode=%0d want lat<=1 0/0/0", obs_lat, obs_label, obs_dist, obs_mode);
    end
    run_op(1'b0, 5'd1, hv_b);
    total++; if (obs_label !== 5'd1 || obs_dist !== 11'd0) begin
      bad++; $display("FAIL train1 got label=%0d dist=%0d want 1/0", obs_label, obs_dist);
    end
    run_op(1'b0, 5'd2, hv_c);
    total++; if (obs_label !== 5'd2 || obs_dist !== 11'd0) begin
      bad++; $display("FAIL train2 got label=%0d dist=%0d want 2/0", obs_label, obs_dist);
    end
    run_op(1'b1, 5'd9, hv_a);
    total++; if (obs_lat !== PRED_LAT) begin bad++; $display("FAIL predict_latency got=%0d want=%0d", obs_lat, PRED_LAT); end
    total++; if (obs_label !== 5'd0 || obs_dist !== 11'd0 || obs_mode !== 1'b1) begin
      bad++; $display("FAIL predict_a got label=%0d dist=%0d mode=%0d want 0/0/1", obs_label, obs_dist, obs_mode);
    end
  endtask

  task automatic test_noise;
    hv_q = hv_a;
    hv_q[3] = ~hv_q[3];     hv_q[17] = ~hv_q[17];     hv_q[250] = ~hv_q[250];
    hv_q[999] = ~hv_q[999]; hv_q[1500] = ~hv_q[1500]; hv_q[1800] = ~hv_q[1800];
    hv_q[1999] = ~hv_q[1999];
    run_op(1'b1, 5'd0, hv_q);
    total++; if (obs_label !== 5'd0 || obs_dist !== 11'd7) begin
      bad++; $display("FAIL noise7 got label=%0d dist=%0d want 0/7", obs_label, obs_dist);
    end
    hv_q = hv_a;
    hv_q[1999] = ~hv_q[1999];
    run_op(1'b1, 5'd0, hv_q);
    total++; if (obs_label !== 5'd0 || obs_dist !== 11'd1) begin
      bad++; $display("FAIL noise_last_bit got label=%0d dist=%0d want 0/1", obs_label, obs_dist);
    end
  endtask

  task automatic test_tie;
    run_op(1'b0, 5'd3, hv_b);
    total++; if (obs_label !== 5'd3 || obs_dist !== 11'd0) begin
      bad++; $display("FAIL train3 got label=%0d dist=%0d want 3/0", obs_label, obs_dist);
    end
    run_op(1'b1, 5'd0, hv_b);
    total++; if (obs_label !== 5'd1 || obs_dist !== 11'd0) begin
      bad++; $display("FAIL tie_lowest got label=%0d dist=%0d want 1/0", obs_label, obs_dist);
    end
  endtask

  task automatic test_backpressure;
    bit to;
    bit stable;
    ready_in = 1'b0;
    start_op(1'b1, 5'd0, hv_c, to);
    wait_result(obs_lat);
    total++; if (to || obs_lat !== PRED_LAT || obs_label !== 5'd2 || obs_dist !== 11'd0) begin
      bad++; $display("FAIL bp_result got lat=%0d label=%0d dist=%0d want %0d 2/0", obs_lat, obs_label, obs_dist, PRED_LAT);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b1 || label_out !== 5'd2 || dist_out !== 11'd0 || mode_out !== 1'b1 || ready_out !== 1'b0)
        stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin
      bad++; $display("FAIL bp_hold got valid=%0b label=%0d dist=%0d ready=%0b want 1/2/0/0", valid_out, label_out, dist_out, ready_out);
    end
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    total++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", valid_out, ready_out);
    end
  endtask

  task automatic test_reset_abort;
    bit to;
    bit seen;
    start_op(1'b1, 5'd0, hv_a, to);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL abort_in_reset got ready=%0b valid=%0b want 0/0", ready_out, valid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_output got seen=%0b want=0", seen); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b want=1", ready_out); end
    run_op(1'b1, 5'd0, hv_a);
    total++; if (obs_lat !== PRED_LAT || obs_label !== 5'd31 || obs_dist !== 11'd2047) begin
      bad++; $display("FAIL abort_untrained got lat=%0d label=%0d dist=%0d want %0d 31/2047", obs_lat, obs_label, obs_dist, PRED_LAT);
    end
  endtask

  task automatic test_bad_label;
    run_op(1'b0, 5'd7, hv_c);
    total++; if (obs_label !== 5'd7 || obs_dist !== 11'd2047 || obs_mode !== 1'b0) begin
      bad++; $display("FAIL bad_label got label=%0d dist=%0d mode=%0d want 7/2047/0", obs_label, obs_dist, obs_mode);
    end
    run_op(1'b1, 5'd0, hv_c);
    total++; if (obs_label !== 5'd31 || obs_dist !== 11'd2047) begin
      bad++; $display("FAIL bad_label_predict got label=%0d dist=%0d want 31/2047", obs_label, obs_dist);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(HV); i++) begin
      hv_a[i] = 1'($urandom_range(0, 1));
      hv_b[i] = 1'($urandom_range(0, 1));
      hv_c[i] = 1'($urandom_range(0, 1));
    end
    test_reset;
    test_train_predict;
    test_noise;
    test_tie;
    test_backpressure;
    test_reset_abort;
    test_bad_label;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
